mips_muldiv_alu: RTL
====================

Name: mips_muldiv_alu

Overview:
Parametrised, multi-cycle successor to the single-cycle MIPS ALU. It keeps the logic, add/sub and set-less-than operations, and adds iterative multiply and divide with architectural HI/LO registers, plus MFHI/MFLO reads. It sits in the execute stage of the multi-cycle MIPS CPU and talks to the control FSM through a valid/ready request and a one-cycle result pulse. All results are registered.

Parameters:
WIDTH, 32, datapath width in bits (>=4). Sets the A/B/Y/HI/LO width and the iteration count.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  request valid.
in_ready  out  1  block idle and able to accept a request.
op  in  4  operation code (see Behaviour).
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
out_valid  out  1  one-cycle pulse: y, zero, ovf, dz valid.
y  out  WIDTH  result.
zero  out  1  y == 0.
ovf  out  1  signed overflow (ADD/SUB only).
dz  out  1  divide by zero on the completed DIV/DIVU.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; y, hi, lo = 0; zero=1; out_valid, ovf, dz = 0; counter = 0.
- Handshake: a request is accepted when in_valid && in_ready. in_ready = (state==IDLE). out_valid has no backpressure: the consumer must sample it in that cycle. a, b and op are captured at acceptance; later input changes are ignored.
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 0011 SLTU.
  - 0100 AND~B, 0101 OR~B.
  - 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU.
  - 1100 MFHI, 1101 MFLO.
  - Others: y=0, out_valid still pulses.
- Single-cycle ops (logic, add/sub, SLT/SLTU, MFHI/MFLO, illegal): accepted in cycle 0; out_valid=1 in cycle 1. in_ready stays high, so back-to-back issue is allowed.
- Arithmetic and width rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - ovf = operands have equal effective sign and the result sign differs.
  - SLT uses the signed compare and is correct even when the subtraction overflows.
  - zero is computed from the registered y.
- FSM: IDLE -> MUL | DIV -> FIX -> IDLE.
  - IDLE: accepts requests. A mul/div op takes the magnitudes of a and b when signed, clears the counter, and sets in_ready=0.
  - MUL: shift-add, one bit per cycle, for WIDTH cycles. The 2*WIDTH-bit product is held in {acc, mplier}.
  - DIV: restoring division, one quotient bit per cycle, for WIDTH cycles.
  - FIX (1 cycle): applies the sign correction, then writes hi/lo.
    - MULT: {hi,lo} = signed product.
    - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of a.
  - After FIX: out_valid=1, y=lo, return to IDLE.
  - Mul/div latency: out_valid in cycle WIDTH+2 after acceptance. in_ready returns high in that same cycle.
- Divide by zero (b==0, DIV/DIVU): skip iterations and go straight to FIX. hi=a, lo=all ones, dz=1, out_valid in cycle 2.
- Signed corner case: DIV of -2^(WIDTH-1) by -1 gives lo=-2^(WIDTH-1), hi=0, ovf=0.
- hi/lo change only in FIX. The single-cycle ops never modify them.
- ovf and dz are 0 on every op other than ADD/SUB and DIV/DIVU respectively.
- Reset asserted mid-operation aborts immediately: all state returns to reset values, no out_valid.

Decomposition:
- Package mips_alu_pkg:
  - alu_op_e (4-bit enum of the op codes above).
  - state_e {IDLE, MUL, DIV, FIX}.
  - is_muldiv() helper function.
- One natural sub-module: muldiv_iter. It holds the MUL/DIV iteration datapath (acc, shift register, counter) and exposes start, is_div, done and the raw result.
- The top module holds the single-cycle ALU, the FSM, sign fix-up and HI/LO.

Test Plan:
- WIDTH=32, ADD a=0x7FFFFFFF b=1 -> cycle 1: y=0x80000000, ovf=1, zero=0. Next cycle SUB a=5 b=5 -> y=0, zero=1, ovf=0.
- SLT a=0x80000000 b=1 -> y=1. SLTU with the same operands -> y=0. Both issued back-to-back, out_valid on two consecutive cycles.
- MULT a=-3 (0xFFFFFFFD) b=7 -> out_valid exactly 34 cycles after acceptance, hi=0xFFFFFFFF, lo=0xFFFFFFEB, in_ready low for cycles 1-33. Then MFHI -> y=0xFFFFFFFF.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=0 -> cycle 2: dz=1, lo=0xFFFFFFFF, hi=7.
- Assert rst_n=0 at cycle 10 of a MULTU -> hi=lo=y=0 immediately, no out_valid. A new request is accepted once rst_n is high.
- WIDTH=8 build, MULTU a=0xFF b=0xFF -> hi=0xFE, lo=0x01, latency 10 cycles.

Source files
------------

// File: rtl/mips_muldiv_alu_pkg.sv
// Shared definitions for the multi-cycle MIPS ALU: op codes, FSM states and
// op classification helpers.
package mips_alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SLTU  = 4'b0011,
        OP_ANDN  = 4'b0100,
        OP_ORN   = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_MULT  = 4'b1000,
        OP_MULTU = 4'b1001,
        OP_DIV   = 4'b1010,
        OP_DIVU  = 4'b1011,
        OP_MFHI  = 4'b1100,
        OP_MFLO  = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

    // MULT and DIV are the even codes of the mul/div group
    function automatic logic is_signed_muldiv(input logic [3:0] op);
        return is_muldiv(op) && !op[0];
    endfunction

endpackage

// File: rtl/mips_muldiv_alu_if.sv
// Request/result bus between the control FSM (master) and the ALU (slave).
interface mips_muldiv_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             ovf;
    logic             dz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, op, a, b,
        input  in_ready, out_valid, y, zero, ovf, dz, hi, lo
    );

    modport slave (
        input  in_valid, op, a, b,
        output in_ready, out_valid, y, zero, ovf, dz, hi, lo
    );
endinterface

// File: rtl/mips_muldiv_alu_muldiv_iter.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide, one
// bit per cycle over WIDTH cycles. Operates on magnitudes only.
module muldiv_iter
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             run,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic             done,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] sreg
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc_q, sreg_q, opb_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;

    always_comb begin
        addend    = sreg_q[0] ? opb_q : '0;
        mul_sum   = {1'b0, acc_q} + {1'b0, addend};
        div_shift = {acc_q, sreg_q[WIDTH-1]};
        // Remainder stays below the divisor, so bit WIDTH of the trial is the borrow
        div_trial = div_shift - {1'b0, opb_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            sreg_q <= '0;
            opb_q  <= '0;
            cnt_q  <= '0;
        end else if (start) begin
            acc_q  <= '0;
            sreg_q <= a_mag;
            opb_q  <= b_mag;
            cnt_q  <= '0;
        end else if (run) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (is_div) begin
                if (!div_trial[WIDTH]) begin
                    acc_q  <= div_trial[WIDTH-1:0];
                    sreg_q <= {sreg_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_q  <= div_shift[WIDTH-1:0];
                    sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_q  <= mul_sum[WIDTH:1];
                sreg_q <= {mul_sum[0], sreg_q[WIDTH-1:1]};
            end
        end
    end

    assign done = (cnt_q == CNT_W'(WIDTH - 1));
    assign acc  = acc_q;
    assign sreg = sreg_q;

endmodule

// File: rtl/mips_muldiv_alu.sv
// Multi-cycle MIPS execute-stage ALU: registered single-cycle ops plus
// iterative MULT/DIV with architectural HI/LO.
module mips_muldiv_alu
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    mips_muldiv_alu_if.slave bus
);
    state_e state_q, state_d;

    logic             in_ready, accept, start_md, run_md, iter_done, sgn;
    logic [WIDTH-1:0] a_mag, b_mag, iter_acc, iter_sreg;
    logic [WIDTH-1:0] a_q;
    logic             is_div_q, neg_lo_q, neg_hi_q, dz_pend_q;
    logic [WIDTH-1:0] y_q, hi_q, lo_q;
    logic             out_valid_q, ovf_q, dz_q;
    logic [WIDTH-1:0] alu_y, add_r, sub_r, fix_hi, fix_lo;
    logic             alu_ovf;
    logic [2*WIDTH-1:0] prod;

    assign accept = in_ready && bus.in_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state; a zero divisor skips the iterations entirely
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && is_muldiv(bus.op)) begin
                    if (bus.op[1]) state_d = (bus.b == '0) ? FIX : DIV;
                    else           state_d = MUL;
                end
            end
            MUL, DIV: if (iter_done) state_d = FIX;
            FIX:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready = (state_q == IDLE);
        run_md   = (state_q == MUL) || (state_q == DIV);
        start_md = (state_q == IDLE) && bus.in_valid && is_muldiv(bus.op);
    end

    always_comb begin
        add_r   = bus.a + bus.b;
        sub_r   = bus.a - bus.b;
        alu_y   = '0;
        alu_ovf = 1'b0;
        case (alu_op_e'(bus.op))
            OP_AND:  alu_y = bus.a & bus.b;
            OP_OR:   alu_y = bus.a | bus.b;
            OP_ANDN: alu_y = bus.a & ~bus.b;
            OP_ORN:  alu_y = bus.a | ~bus.b;
            OP_ADD: begin
                alu_y   = add_r;
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_r[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_y   = sub_r;
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_r[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_MFHI: alu_y = hi_q;
            OP_MFLO: alu_y = lo_q;
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        sgn   = is_signed_muldiv(bus.op);
        a_mag = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    // Sign fix-up of the unsigned iteration result
    always_comb begin
        prod = {iter_acc, iter_sreg};
        if (neg_lo_q) prod = -prod;
        if (dz_pend_q) begin
            fix_hi = a_q;
            fix_lo = '1;
        end else if (is_div_q) begin
            fix_lo = neg_lo_q ? -iter_sreg : iter_sreg;
            fix_hi = neg_hi_q ? -iter_acc  : iter_acc;
        end else begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            a_q         <= '0;
            is_div_q    <= 1'b0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            dz_pend_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (accept) begin
                if (is_muldiv(bus.op)) begin
                    a_q       <= bus.a;
                    is_div_q  <= bus.op[1];
                    neg_lo_q  <= sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    neg_hi_q  <= sgn && bus.a[WIDTH-1];
                    dz_pend_q <= bus.op[1] && (bus.b == '0);
                end else begin
                    y_q         <= alu_y;
                    ovf_q       <= alu_ovf;
                    dz_q        <= 1'b0;
                    out_valid_q <= 1'b1;
                end
            end
            if (state_q == FIX) begin
                hi_q        <= fix_hi;
                lo_q        <= fix_lo;
                y_q         <= fix_lo;
                ovf_q       <= 1'b0;
                dz_q        <= dz_pend_q;
                out_valid_q <= 1'b1;
            end
        end
    end

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_md),
        .run    (run_md),
        .is_div (is_div_q),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .done   (iter_done),
        .acc    (iter_acc),
        .sreg   (iter_sreg)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.zero      = (y_q == '0);
    assign bus.ovf       = ovf_q;
    assign bus.dz        = dz_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule
